// File: rtl/hs_pkg.sv
// -----------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the handshake schedulers (hs_rr_arbiter, rr_pick).
//   HS_MAX_REQ  : largest requester count any scheduler is built for
//   clog2_min1  : ceil(log2(n)), never less than 1, for index widths
//   hs_src_id_t : source-id type wide enough for HS_MAX_REQ requesters
// -----------------------------------------------------------------------------
package hs_pkg;

    localparam int HS_MAX_REQ = 16;

    // Index width for n items; a single item still needs a 1-bit field.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    typedef logic [clog2_min1(HS_MAX_REQ)-1:0] hs_src_id_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin pick: rotate the request vector so that
// index ptr sits at bit 0, take the lowest set bit, then rotate the result back.
// Ports:
//   req  [N-1:0]   in   request vector
//   ptr  [IDW-1:0] in   highest-priority index (must be < N)
//   gnt  [N-1:0]   out  one-hot grant, zero when req is zero
//   gidx [IDW-1:0] out  index of the granted requester (0 when req is zero)
// -----------------------------------------------------------------------------
module rr_pick
    import hs_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2_min1(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gidx
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_rot;
    logic [N-1:0]   w_rot_n;
    logic [IDW-1:0] w_off;
    logic [IDW:0]   w_sum;
    logic           w_any;

    // Rotate right by ptr through a doubled copy so wrap-around comes for free.
    always_comb begin
        w_dbl   = {req, req};
        w_rot   = w_dbl >> ptr;
        w_rot_n = w_rot[N-1:0];
        w_any   = |req;
    end

    // Lowest set bit of the rotated vector; descending scan lets the lowest win.
    always_comb begin
        w_off = {IDW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot_n[i]) begin
                w_off = IDW'(i);
            end else begin
                w_off = w_off;
            end
        end
    end

    // Unrotate: ptr + offset modulo N, kept below N for non-power-of-2 N.
    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (IDW+1)'(N)) begin
            gidx = IDW'(w_sum - (IDW+1)'(N));
        end else begin
            gidx = w_sum[IDW-1:0];
        end
        if (w_any) begin
            gnt = {{(N-1){1'b0}}, 1'b1} << gidx;
        end else begin
            gnt = {N{1'b0}};
        end
    end

endmodule

// File: rtl/hs_rr_arbiter.sv
// -----------------------------------------------------------------------------
// hs_rr_arbiter
// N-way round-robin arbiter feeding one registered valid/ready output stage.
// Build option: define HS_ARB_BURST_EN to let a requester keep the grant for up
// to BURST consecutive beats while it keeps requesting.
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-high
//   valid_i  in   [N]     per-requester valid
//   ready_o  out  [N]     per-requester ready, one-hot or zero (combinational)
//   din      in   [N*W]   requester data, requester k at [k*W +: W]
//   valid_o  out          downstream valid (registered)
//   ready_i  in           downstream ready
//   dout     out  [W]     registered winning data
//   src_o    out  [IDW]   registered index of the requester held in dout
// -----------------------------------------------------------------------------
module hs_rr_arbiter
    import hs_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 3,
    parameter int IDW   = clog2_min1(N),
    parameter int BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   valid_i,
    output logic [N-1:0]   ready_o,
    input  logic [N*W-1:0] din,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [W-1:0]   dout,
    output logic [IDW-1:0] src_o
);

    logic           r_full;
    logic [W-1:0]   r_dout;
    logic [IDW-1:0] r_src;
    logic [IDW-1:0] r_ptr;

    logic           w_wr_en;
    logic           w_any;
    logic [N-1:0]   w_gnt;
    logic [IDW-1:0] w_gidx;
    logic [W-1:0]   w_win_data;
    logic [IDW-1:0] w_ptr_inc;
    logic [IDW-1:0] w_ptr_nxt;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req  (valid_i),
        .ptr  (r_ptr),
        .gnt  (w_gnt),
        .gidx (w_gidx)
    );

    // Stage enable, handshake outputs; ready is suppressed during reset so a
    // requester never sees a beat taken that the reset then discards.
    always_comb begin
        w_wr_en = ~r_full | ready_i;
        w_any   = |valid_i;
        if (rst) begin
            ready_o = {N{1'b0}};
        end else begin
            ready_o = w_gnt & {N{w_wr_en}};
        end
        valid_o = r_full;
        dout    = r_dout;
        src_o   = r_src;
    end

    // One-hot AND-OR mux of the winning requester's data.
    always_comb begin
        w_win_data = {W{1'b0}};
        for (int k = 0; k < N; k++) begin
            w_win_data = w_win_data | ({W{w_gnt[k]}} & din[k*W +: W]);
        end
    end

    // Pointer just past the winner, wrapping N-1 -> 0.
    always_comb begin
        if (w_gidx == IDW'(N - 1)) begin
            w_ptr_inc = {IDW{1'b0}};
        end else begin
            w_ptr_inc = w_gidx + IDW'(1'b1);
        end
    end

`ifdef HS_ARB_BURST_EN
    logic [3:0] r_bcnt;
    logic [3:0] w_bcnt_cur;
    logic [4:0] w_bcnt_inc;
    logic [3:0] w_bcnt_nxt;

    // Count only continues while the same requester keeps winning; the pointer
    // stays on the winner until it has had BURST beats in a row.
    always_comb begin
        if (w_gidx == r_src) begin
            w_bcnt_cur = r_bcnt;
        end else begin
            w_bcnt_cur = 4'd0;
        end
        w_bcnt_inc = {1'b0, w_bcnt_cur} + 5'd1;
        if (w_bcnt_inc < 5'(BURST)) begin
            w_ptr_nxt  = w_gidx;
            w_bcnt_nxt = w_bcnt_inc[3:0];
        end else begin
            w_ptr_nxt  = w_ptr_inc;
            w_bcnt_nxt = 4'd0;
        end
    end

    // Burst counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt <= 4'd0;
        end else if (w_wr_en && w_any) begin
            r_bcnt <= w_bcnt_nxt;
        end else begin
            r_bcnt <= r_bcnt;
        end
    end
`else
    // Plain round-robin: always move past the winner.
    always_comb begin
        w_ptr_nxt = w_ptr_inc;
    end
`endif

    // Output stage and priority pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_dout <= {W{1'b0}};
            r_src  <= {IDW{1'b0}};
            r_ptr  <= {IDW{1'b0}};
        end else if (w_wr_en) begin
            if (w_any) begin
                r_full <= 1'b1;
                r_dout <= w_win_data;
                r_src  <= w_gidx;
                r_ptr  <= w_ptr_nxt;
            end else begin
                // Drained with nothing to replace it; keep last data visible.
                r_full <= 1'b0;
                r_dout <= r_dout;
                r_src  <= r_src;
                r_ptr  <= r_ptr;
            end
        end else begin
            r_full <= r_full;
            r_dout <= r_dout;
            r_src  <= r_src;
            r_ptr  <= r_ptr;
        end
    end

endmodule

// File: doc/hs_rr_arbiter.md
Name: hs_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered valid/ready pipeline stage between N upstream requesters.
- Each requester presents a valid/ready/data channel. The arbiter picks at most one winner per cycle and loads its data into a single output register.
- The output register drives a standard valid/ready downstream channel.
- Sits in front of any shared single-channel consumer, such as a bus master port or a shared FIFO write side.

Parameters:
- N, 4, number of requesters (2..16)
- W, 3, data width per requester
- IDW, $clog2(N), width of the source-id field
- BURST, 4, max consecutive grants to one requester (used only with HS_ARB_BURST_EN; 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- valid_i  in  N  per-requester valid
- ready_o  out  N  per-requester ready (one-hot or zero)
- din  in  N*W  requester data; requester k occupies bits [k*W +: W]
- valid_o  out  1  downstream valid
- ready_i  in  1  downstream ready
- dout  out  W  registered winning data
- src_o  out  IDW  registered index of the requester whose data is in dout

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: full=0, valid_o=0, dout=0, src_o=0, ptr=0, burst counter=0.
- Stage enable: wr_en = ~full | ready_i. The stage accepts a new beat when empty, or when downstream drains it in the same cycle.
- Arbitration (combinational, every cycle):
  - Search valid_i starting at index ptr, ascending with wrap at N-1 -> 0.
  - The first set bit is the winner g.
  - gnt is one-hot on g; gnt=0 if valid_i==0.
- ready_o = gnt & {N{wr_en}}.
  - ready_o depends combinationally on valid_i and ready_i.
  - Requesters must not make valid_i depend on ready_o.
- Transfer on rising clk when wr_en=1:
  - If any valid_i is set: full<=1, dout<=din[g], src_o<=g, ptr<=(g+1) mod N.
  - If no valid_i is set: full<=0, dout and src_o hold.
- When wr_en=0: all state holds; ready_o=0.
- valid_o = full. Latency is 1 cycle from accept to valid_o.
- Throughput: 1 beat/cycle while ready_i=1.
- Fairness: a requester holding valid_i high waits at most N-1 grants to others.
- Losing requesters keep valid_i and din stable; the arbiter does not latch them.
- Boundary conditions:
  - Simultaneous drain and fill (full=1, ready_i=1, a valid present): new beat loaded, valid_o stays 1 with no bubble.
  - Downstream stall (full=1, ready_i=0): ready_o=0, dout/src_o stable, pointer frozen.
  - Pointer wrap: g=N-1 gives ptr<=0.
  - Reset mid-transfer: the held beat is discarded, ptr returns to 0, and no ready_o is asserted in the reset cycle.
- Non-power-of-2 N: ptr never exceeds N-1. src_o is zero-extended to IDW.

Optional Feature:
- Macro: HS_ARB_BURST_EN
- Enabled:
  - After an accepted grant to g, if valid_i[g] is still 1 and bcnt+1 < BURST, ptr stays at g and bcnt increments.
  - Otherwise ptr<=(g+1) mod N and bcnt<=0.
  - bcnt also clears whenever the winner changes.
  - Worst-case wait becomes (N-1)*BURST grants.
- Disabled: no bcnt register; pure round-robin as above, and BURST is ignored.

Decomposition:
- Shared package hs_pkg holds:
  - constant HS_MAX_REQ = 16
  - function clog2_min1 (returns at least 1)
  - typedef for the source-id width
- One natural sub-module: rr_pick. It is the purely combinational rotate / priority-encode / unrotate circuit.
  - Inputs: req[N], ptr.
  - Outputs: gnt one-hot and gidx.
  - Reused by later schedulers.
- The output register and pointer logic stay in hs_rr_arbiter.

Test Plan:
- Reset then single requester: valid_i=4'b0100, din[2]=3'h5, ready_i=1. Expected: ready_o=4'b0100 that cycle; next cycle valid_o=1, dout=5, src_o=2, ptr=3.
- All requesting, ready_i=1 for 8 cycles, starting with ptr=0. Expected: src_o sequence 0,1,2,3,0,1,2,3; exactly one ready_o bit per cycle.
- Backpressure: full=1, ready_i=0 for 3 cycles, valid_i=4'b1111. Expected: ready_o=0, and dout/src_o/ptr unchanged. On ready_i=1, the next requester is accepted with no bubble.
- Drain without new data: full=1, ready_i=1, valid_i=0. Expected: valid_o falls next cycle and dout holds its value.
- Reset asserted while full=1 and valid_i=4'b1010. Expected: next cycle valid_o=0, dout=0, ptr=0; after rst deasserts, requester 1 wins first.
- HS_ARB_BURST_EN with BURST=3, valid_i=4'b0011 held, ready_i=1. Expected: src_o sequence 0,0,0,1,1,1,0. Without the macro: 0,1,0,1.
